// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
//   Frames the UART receiver's byte strobes: SOF, LEN, LEN payload bytes, CHK.
//   A frame is good when (LEN + sum(payload) + CHK) wraps to zero in 8 bits.
//   Good payloads are buffered and replayed over a valid/ready stream only
//   after the checksum passes; bad, stalled or overrunning frames are dropped.
// Ports
//   CLK, reset          clock, synchronous active-high reset
//   rx_data, rx_valid   byte from the UART receiver (one-cycle strobe)
//   out_data/valid/last payload stream, out_ready is the downstream accept
//   frame_ok, frame_err one-cycle result pulses; err_code holds last reason
//                       (01 bad LEN, 10 checksum, 11 inter-byte timeout)
//   led_q               first payload byte of the most recent good frame
//   rx_overrun          sticky: a byte arrived while draining and was dropped
//   busy                high whenever a frame is in progress or draining
module uart_frame_decoder #(
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 40000,
  parameter logic [7:0] SOF         = 8'h7E
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] led_q,
  output logic       rx_overrun,
  output logic       busy
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t         r_state;
  logic [7:0]     r_buf [MAX_LEN];
  logic [LW-1:0]  r_len;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  r_rd_idx;
  logic [7:0]     r_acc;
  logic [TW-1:0]  r_tcnt;
  logic [7:0]     r_out_data, r_led_q;
  logic           r_out_valid, r_out_last, r_frame_ok, r_frame_err, r_rx_overrun;
  logic [1:0]     r_err_code;

  logic [7:0]     w_sum;
  logic [IW-1:0]  w_rd_nxt;
  logic           w_wr_last, w_active, w_timeout, w_bad_len;

  assign w_sum     = r_acc + rx_data;
  assign w_rd_nxt  = r_rd_idx + 1'b1;
  assign w_wr_last = (LW'(r_idx) == r_len - LW'(1));
  assign w_bad_len = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
  assign w_active  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  // Counter is 0 in the first cycle after a byte, so hitting TIMEOUT_CYC-2
  // here puts frame_err exactly TIMEOUT_CYC cycles after that byte's strobe.
  // A byte in the same cycle always wins over the timeout.
  assign w_timeout = w_active && !rx_valid && (r_tcnt == TW'(TIMEOUT_CYC - 2));

  // Payload storage carries no reset; stale contents are never presented.
  always_ff @(posedge CLK) begin
    if (!reset && r_state == S_PAYLOAD && rx_valid) r_buf[r_idx] <= rx_data;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_rd_idx     <= '0;
      r_acc        <= '0;
      r_tcnt       <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'b00;
      r_led_q      <= '0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_active) r_tcnt <= rx_valid ? '0 : r_tcnt + 1'b1;
      else          r_tcnt <= '0;

      case (r_state)
        S_IDLE: if (rx_valid && rx_data == SOF) r_state <= S_LEN;
        S_LEN: if (rx_valid) begin
          if (w_bad_len) begin
            r_frame_err <= 1'b1;
            r_err_code  <= 2'b01;
            r_state     <= S_IDLE;
          end else begin
            r_len   <= rx_data[LW-1:0];
            r_acc   <= rx_data;
            r_idx   <= '0;
            r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (rx_valid) begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (w_wr_last) r_state <= S_CHK;
        end
        S_CHK: if (rx_valid) begin
          if (w_sum == 8'h00) begin
            r_frame_ok  <= 1'b1;
            r_led_q     <= r_buf[0];
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[0];
            r_out_last  <= (r_len == LW'(1));
            r_rd_idx    <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_frame_err <= 1'b1;
            r_err_code  <= 2'b10;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // No resync while draining: every strobe here is lost.
          if (rx_valid) r_rx_overrun <= 1'b1;
          if (r_out_valid && out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_rd_idx   <= w_rd_nxt;
              r_out_data <= r_buf[w_rd_nxt];
              r_out_last <= (LW'(w_rd_nxt) == r_len - LW'(1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_frame_err <= 1'b1;
        r_err_code  <= 2'b11;
        r_state     <= S_IDLE;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_ok   = r_frame_ok;
  assign frame_err  = r_frame_err;
  assign err_code   = r_err_code;
  assign led_q      = r_led_q;
  assign rx_overrun = r_rx_overrun;
  assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_frame_decoder;
  localparam int         MAX_LEN = 8;
  localparam int         TO      = 64;
  localparam logic [7:0] SOF     = 8'h7E;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data, led_q;
  logic       out_valid, out_last, frame_ok, frame_err, rx_overrun, busy;
  logic [1:0] err_code;

  uart_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO), .SOF(SOF)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .led_q(led_q), .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  logic rnd_rdy = 1'b0;

  // Model: bytes of the frame being collected, and bytes still to be delivered.
  logic       m_collect = 1'b0;
  logic [7:0] fr [$];
  logic [7:0] dq [$];
  int         m_idle = 0;
  logic       m_ok = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic [7:0] m_led = 8'h00;

  logic [7:0] pay [8] = '{8'hC0, 8'hF0, 8'hFE, 8'hFE, 8'hFC, 8'hFF, 8'h01, 8'h02};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic v, input logic [7:0] d, input logic rdy, input logic rst);
    int s;
    m_ok = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_collect = 1'b0; fr.delete(); dq.delete(); m_idle = 0;
      m_code = 2'b00; m_led = 8'h00; m_ovr = 1'b0;
    end else if (dq.size() != 0) begin
      if (v) m_ovr = 1'b1;
      if (rdy) void'(dq.pop_front());
    end else if (m_collect) begin
      if (v) begin
        fr.push_back(d);
        m_idle = 0;
        if (fr.size() == 1 && (d == 8'd0 || d > MAX_LEN)) begin
          m_err = 1'b1; m_code = 2'b01; m_collect = 1'b0;
        end else if (fr.size() == int'(fr[0]) + 2) begin
          s = 0;
          foreach (fr[i]) s += int'(fr[i]);
          if (s % 256 == 0) begin
            m_ok = 1'b1; m_led = fr[1];
            for (int i = 1; i <= int'(fr[0]); i++) dq.push_back(fr[i]);
          end else begin
            m_err = 1'b1; m_code = 2'b10;
          end
          m_collect = 1'b0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO - 1) begin
          m_err = 1'b1; m_code = 2'b11; m_collect = 1'b0;
        end
      end
    end else if (v && d == SOF) begin
      m_collect = 1'b1; fr.delete(); m_idle = 0;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, dq.size() != 0);
    if (dq.size() != 0) begin
      chk("out_data", out_data, dq[0]);
      chk("out_last", out_last, dq.size() == 1);
    end else chk("out_last_idle", out_last, 1'b0);
    chk("busy", busy, m_collect || dq.size() != 0);
    chk("frame_ok", frame_ok, m_ok);
    chk("frame_err", frame_err, m_err);
    chk("err_code", err_code, m_code);
    chk("led_q", led_q, m_led);
    chk("rx_overrun", rx_overrun, m_ovr);
  endtask

  // One clock: drive, let the DUT sample, advance the model, check at negedge.
  task automatic step(input logic v, input logic [7:0] d);
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    rx_valid = v;
    rx_data  = d;
    @(posedge CLK);
    model(v, d, out_ready, reset);
    @(negedge CLK);
    compare();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
    repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
  endtask

  task automatic rand_frame();
    int kind, len;
    logic [7:0] b, sum;
    kind = $urandom_range(0, 9);
    if (kind == 0) send(8'($urandom_range(0, 125)));
    else if (kind == 1) begin
      send(SOF);
      send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else if (kind == 2) begin
      send(SOF);
      send(8'($urandom_range(1, MAX_LEN)));
      repeat ($urandom_range(0, 2)) send(8'($urandom));
      repeat (TO + 3) step(1'b0, 8'h00);
    end else begin
      len = $urandom_range(1, MAX_LEN);
      sum = 8'(len);
      send(SOF);
      send(8'(len));
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        sum += b;
        send(b);
      end
      b = -sum;
      if (kind == 3) b += 8'($urandom_range(1, 255));
      send(b);
    end
    repeat ($urandom_range(0, 6)) step(1'b0, 8'h00);
  endtask

  initial begin
    int k;
    // Reset state
    reset = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step(1'b0, 8'h00);

    // Good frame 7E 02 01 01 FC, back-to-back bytes
    out_ready = 1'b1;
    step(1'b1, 8'h7E); step(1'b1, 8'h02); step(1'b1, 8'h01); step(1'b1, 8'h01);
    step(1'b1, 8'hFC);
    chk("good_ok", frame_ok, 1'b1);
    chk("good_led", led_q, 8'h01);
    chk("good_d0", out_data, 8'h01);
    chk("good_last0", out_last, 1'b0);
    step(1'b0, 8'h00);
    chk("good_d1", out_data, 8'h01);
    chk("good_last1", out_last, 1'b1);
    step(1'b0, 8'h00);
    chk("good_done_busy", busy, 1'b0);

    // Garbage then bad checksum
    step(1'b1, 8'hF4); step(1'b1, 8'h7E); step(1'b1, 8'h02); step(1'b1, 8'h01);
    step(1'b1, 8'h01); step(1'b1, 8'hFD);
    chk("badchk_err", frame_err, 1'b1);
    chk("badchk_code", err_code, 2'b10);
    step(1'b0, 8'h00);
    chk("badchk_novalid", out_valid, 1'b0);

    // Bad lengths, then 7E 01 55 AA
    step(1'b1, 8'h7E); step(1'b1, 8'h00);
    chk("len0_err", frame_err, 1'b1);
    chk("len0_code", err_code, 2'b01);
    step(1'b0, 8'h00);
    step(1'b1, 8'h7E); step(1'b1, 8'h09);
    chk("len9_err", frame_err, 1'b1);
    chk("len9_code", err_code, 2'b01);
    step(1'b1, 8'h7E); step(1'b1, 8'h01); step(1'b1, 8'h55); step(1'b1, 8'hAA);
    chk("len1_led", led_q, 8'h55);
    chk("len1_data", out_data, 8'h55);
    chk("len1_last", out_last, 1'b1);
    step(1'b0, 8'h00);

    // Timeout: frame_err must land TO cycles after the AA strobe
    step(1'b1, 8'h7E); step(1'b1, 8'h03); step(1'b1, 8'hAA);
    k = 1;
    while (frame_err !== 1'b1 && k < 2 * TO) begin
      step(1'b0, 8'h00);
      k++;
    end
    chk("timeout_cycles", 8'(k), 8'(TO));
    chk("timeout_code", err_code, 2'b11);
    chk("timeout_busy", busy, 1'b0);
    step(1'b0, 8'h00);

    // Backpressure and overrun with a full 8-byte frame (CHK = 4E)
    out_ready = 1'b0;
    step(1'b1, 8'h7E); step(1'b1, 8'h08);
    for (int i = 0; i < 8; i++) step(1'b1, pay[i]);
    step(1'b1, 8'h4E);
    chk("bp_ok", frame_ok, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(i == 5, 8'h7E);
      chk("bp_hold", out_data, 8'hC0);
    end
    chk("bp_overrun", rx_overrun, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_byte", out_data, pay[i]);
      chk("bp_last", out_last, i == 7);
      step(1'b0, 8'h00);
    end
    chk("bp_done", busy, 1'b0);

    // Reset one cycle after the second transfer (03 11 22 33, CHK 97)
    step(1'b1, 8'h7E); step(1'b1, 8'h03); step(1'b1, 8'h11); step(1'b1, 8'h22);
    step(1'b1, 8'h33); step(1'b1, 8'h97);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    reset = 1'b1;
    step(1'b0, 8'h00);
    reset = 1'b0;
    chk("rst_drain_valid", out_valid, 1'b0);
    chk("rst_drain_busy", busy, 1'b0);
    chk("rst_drain_led", led_q, 8'h00);
    chk("rst_drain_ovr", rx_overrun, 1'b0);

    // Randomized traffic with random backpressure and occasional reset
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step(1'b0, 8'h00);
        reset = 1'b0;
      end
      rand_frame();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (20) step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-level framing stage that sits directly downstream of the UART receiver in `ClockBaseTop`. It consumes the receiver's one-cycle byte strobes, delimits frames on a 0x7E start byte, checks a length and checksum, and buffers the payload. Only after the checksum passes does it replay the payload over a valid/ready stream to the shift-register/LED logic. Malformed, stalled or overrunning frames are flagged and dropped, so downstream never sees partial data.

## Interface
- `MAX_LEN`, 8: maximum payload bytes per frame. Legal LEN is 1..MAX_LEN.
- `TIMEOUT_CYC`, 40000: maximum allowed clock cycles between bytes inside a frame (about 2.3 byte times at 57600 baud, 100 MHz).
- `SOF`, 8'h7E: start-of-frame byte.

- `CLK`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  payload byte available.
- `out_ready`  in  1  downstream accepts the byte.
- `out_last`  out  1  qualifies the final payload byte of a frame.
- `frame_ok`  out  1  one-cycle pulse: good frame received.
- `frame_err`  out  1  one-cycle pulse: frame aborted.
- `err_code`  out  2  reason for the abort; valid with `frame_err`, held until the next error. 01 = bad LEN, 10 = checksum, 11 = timeout.
- `led_q`  out  8  first payload byte of the most recent good frame.
- `rx_overrun`  out  1  sticky; set when a byte is dropped during DRAIN. Cleared only by reset.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CHK. The frame is good when (LEN + Σpayload + CHK) mod 256 == 0, using an 8-bit wrapping accumulator.
- No byte stuffing: 0x7E inside LEN, payload or CHK is treated as ordinary data.
- States:
  - IDLE: a byte equal to SOF → LEN. Any other byte is ignored silently, with no error.
  - LEN:
    - LEN==0 or LEN>MAX_LEN → frame_err with code 01, then IDLE.
    - Otherwise latch LEN, set acc=LEN, clear the write index, go to PAYLOAD.
  - PAYLOAD: write the byte to buffer[idx], add it to acc, increment idx. When idx reaches LEN → CHK.
  - CHK:
    - acc+byte==0 → frame_ok, update `led_q`=buffer[0], go to DRAIN.
    - Otherwise → frame_err with code 10, then IDLE. The buffer is discarded.
  - DRAIN: present buffer[0..LEN-1] in order. After the transfer of the last byte → IDLE.
- Timeout:
  - A cycle counter runs in LEN, PAYLOAD and CHK, and is cleared by each accepted rx_valid.
  - When it reaches TIMEOUT_CYC with no rx_valid → frame_err with code 11, then IDLE.
  - If rx_valid arrives in the same cycle as the timeout, the byte wins and no timeout is raised.
  - The counter is inactive in IDLE and DRAIN.
- During DRAIN, any rx_valid is dropped and sets `rx_overrun`. The decoder does not resynchronise to a SOF seen in DRAIN.
- reset mid-frame or mid-drain: return to IDLE on the next edge. The buffer content is abandoned and `out_valid` drops.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=00, `led_q`=00, `rx_overrun`=0, `busy`=0, state IDLE.
- CHK byte strobed in cycle t:
  - `frame_ok`, `led_q` update and first `out_valid` all occur in cycle t+1.
  - On a bad checksum, `frame_err` occurs in cycle t+1 instead.
- Handshake:
  - A transfer happens on a cycle with out_valid && out_ready; the next byte is presented the following cycle.
  - While out_valid && !out_ready, `out_data` and `out_last` are held stable.
  - `out_valid` never drops without a transfer, except on reset.
- With `out_ready` held high, LEN bytes drain in LEN consecutive cycles. `busy` falls the cycle after the last transfer.
- The first LEN byte may arrive in the cycle immediately after SOF; consecutive-cycle rx_valid is supported.
- The decoder accepts a SOF in the cycle immediately after it returns to IDLE.

## Test plan
- Good frame: 7E 02 01 01 FC with `out_ready`=1 → `frame_ok` one cycle after FC. Output 01 then 01, with `out_last` on the second. `led_q`=01, no `frame_err`.
- Bad checksum and leading garbage: F4 7E 02 01 01 FD → F4 is ignored. `frame_err` fires with `err_code`=10, and `out_valid` never rises.
- Bad length: 7E 00, then separately 7E 09 → two `frame_err` pulses with `err_code`=01. A following 7E 01 55 AA frame is decoded correctly: output 55, `led_q`=55.
- Timeout: 7E 03 AA, then silence → `frame_err` with `err_code`=11 exactly TIMEOUT_CYC cycles after AA, then IDLE (`busy`=0).
- Backpressure and overrun: full 8-byte frame 7E 08 C0 F0 FE FE FC FF 01 02 plus the correct CHK, with `out_ready`=0 for 20 cycles → `out_data` held at C0. Strobing 7E during the stall sets `rx_overrun`=1. After `out_ready`=1, all 8 bytes come out in order.
- Reset mid-drain: assert `reset` one cycle after the second transfer → `out_valid`=0 and `busy`=0 next cycle, and `led_q` returns to 00.
